instruction_fetch_unit: RTL



---
 rtl/processor_pkg.sv | 15 +
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instruction_fetch_unit.sv | 73 +++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared processor types: word width, instruction/address words and the
// {pc, data} entry carried through the fetch prefetch buffer.
package processor_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WORD_W-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    word_t data;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: control-unit redirect, instruction RAM port and the
// instruction handshake toward decode. master = fetch unit, slave = its peers.
interface instruction_fetch_unit_if;
  import processor_pkg::*;

  logic  redirect_valid;
  addr_t redirect_pc;
  addr_t mem_a;
  logic  mem_rw;
  word_t mem_dout;
  logic  inst_valid;
  word_t inst_data;
  addr_t inst_pc;
  logic  inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_dout, inst_ready,
    output mem_a, mem_rw, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_dout, inst_ready,
    input  mem_a, mem_rw, inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head is presented combinationally
// from storage and reads as zero while the FIFO is empty.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: storage has no reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues RAM reads against
// FIFO credit, buffers returned words and handles branch redirects.
module instruction_fetch_unit
  import processor_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0,
  parameter int    DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  addr_t        r_fetch_pc;
  logic         r_pending;
  addr_t        r_pending_pc;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_credit;
  logic             w_issue;
  logic             w_push;
  logic             w_valid;
  fetch_entry_t     w_din;
  fetch_entry_t     w_head;

  // In-flight read already owns a slot, so a push can never find the FIFO full.
  assign w_credit = w_count + CNT_W'(r_pending);
  assign w_issue  = !bus.redirect_valid && (w_credit < CNT_W'(DEPTH));
  assign w_push   = r_pending && !bus.redirect_valid;
  assign w_din    = '{pc: r_pending_pc, data: bus.mem_dout};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_fetch_pc   <= r_fetch_pc + 32'd1;
        r_pending_pc <= r_fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (bus.inst_ready),
    .i_flush (bus.redirect_valid),
    .i_din   (w_din),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_head  (w_head)
  );

  assign bus.mem_a      = r_fetch_pc;
  assign bus.mem_rw     = 1'b0;
  assign bus.inst_valid = w_valid;
  assign bus.inst_data  = w_head.data;
  assign bus.inst_pc    = w_head.pc;

endmodule
